// File: rtl/material_eval_seq.sv
// -----------------------------------------------------------------------------
// material_eval_seq
//
// Sequential material evaluator for the chess engine datapath. On an accepted
// start it either returns a fixed terminal score (checkmate / stalemate) or
// scans the 64-square board memory, LANES squares per cycle, over a registered
// read port and reports the clamped signed material balance
// (positive = white ahead).
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   start           evaluation request, honoured only in IDLE
//   mate            side to move is checkmated          (captured on accept)
//   stalemate       side to move has no legal move       (captured on accept)
//   white_to_move   1 = white to move                    (captured on accept)
//   busy            high from the cycle after accept until (and including) done
//   done            one-cycle pulse, score/outcome valid from this cycle
//   score           signed evaluation, held until the next done
//   outcome         00 ongoing, 10 white wins, 01 black wins, 11 draw
//   bad_piece       sticky per scan, set when any square holds type 7
//   rd_en/rd_addr   board read request; rd_addr is the first square of a group
//   rd_data         LANES piece codes, lane k = square rd_addr+k, 1 cycle late
//   dbg_state       current FSM state, for observation only
//
// Handshake: start is a level sampled on a rising edge while the FSM is IDLE;
// that edge is the accept edge. Exactly one done pulse follows every accepted
// start unless rst intervenes. start at any other time, including the DONE
// cycle, has no effect.
//
// Piece code: bit3 colour (0 white, 1 black), bits[2:0] type
//   0 empty, 1 P, 2 N, 3 B, 4 R, 5 Q, 6 K (value 0), 7 invalid (value 0).
// -----------------------------------------------------------------------------
module material_eval_seq #(
  parameter int SCORE_W    = 16,
  parameter int LANES      = 1,
  parameter int VAL_P      = 1,
  parameter int VAL_N      = 3,
  parameter int VAL_B      = 3,
  parameter int VAL_R      = 5,
  parameter int VAL_Q      = 10,
  parameter int MATE_SCORE = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               mate,
  input  logic               stalemate,
  input  logic               white_to_move,
  output logic               busy,
  output logic               done,
  output logic [SCORE_W-1:0] score,
  output logic [1:0]         outcome,
  output logic               bad_piece,
  output logic               rd_en,
  output logic [5:0]         rd_addr,
  input  logic [4*LANES-1:0] rd_data,
  output logic [2:0]         dbg_state
);

  // ---------------------------------------------------------------------------
  // Sizing
  // ---------------------------------------------------------------------------
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Largest single piece value; the accumulator must hold +/-64 of them.
  localparam int VMAX  = max2(max2(max2(VAL_P, VAL_N), max2(VAL_B, VAL_R)),
                              max2(VAL_Q, 1));
  localparam int ACC_W = $clog2(64 * VMAX + 1) + 1;
  // Common signed width used for the clamp compare, wide enough for both the
  // accumulator and any legal MATE_SCORE.
  localparam int EXT_W = 34;

  localparam logic signed [EXT_W-1:0] LIM_HI   = EXT_W'(MATE_SCORE - 1);
  localparam logic signed [EXT_W-1:0] LIM_LO   = -LIM_HI;
  localparam logic [SCORE_W-1:0]      MATE_POS = SCORE_W'(MATE_SCORE);
  localparam logic [SCORE_W-1:0]      MATE_NEG = SCORE_W'(-MATE_SCORE);
  localparam logic [6:0]              LAST_ADDR = 7'(64 - LANES);
  localparam logic [5:0]              ADDR_STEP = 6'(LANES);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SCAN  = 3'd1,
    S_DRAIN = 3'd2,
    S_TERM  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t                    r_state;
  logic                      r_busy;
  logic                      r_done;
  logic [SCORE_W-1:0]        r_score;
  logic [1:0]                r_outcome;
  logic                      r_bad;
  logic                      r_rd_en;
  logic [5:0]                r_rd_addr;
  logic                      r_beat;     // rd_data carries a valid group this cycle
  logic                      r_mate;
  logic                      r_wtm;
  logic signed [ACC_W-1:0]   r_acc;

  logic signed [ACC_W-1:0]   w_beat_sum;
  logic                      w_beat_bad;
  logic signed [ACC_W-1:0]   w_acc_next;
  logic signed [EXT_W-1:0]   w_acc_ext;
  logic signed [EXT_W-1:0]   w_clamped;
  logic [SCORE_W-1:0]        w_score_mat;
  logic                      w_last_addr;

  // ---------------------------------------------------------------------------
  // Lane decode and per-beat sum
  // ---------------------------------------------------------------------------
  function automatic logic signed [ACC_W-1:0] piece_val(input logic [2:0] t);
    case (t)
      3'd1:    return ACC_W'(VAL_P);
      3'd2:    return ACC_W'(VAL_N);
      3'd3:    return ACC_W'(VAL_B);
      3'd4:    return ACC_W'(VAL_R);
      3'd5:    return ACC_W'(VAL_Q);
      default: return '0;   // empty, king and invalid carry no material
    endcase
  endfunction

  always_comb begin
    w_beat_sum = '0;
    w_beat_bad = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      if (rd_data[4*k +: 3] == 3'd7) begin
        w_beat_bad = 1'b1;
      end
      if (rd_data[4*k + 3]) begin
        w_beat_sum = w_beat_sum - piece_val(rd_data[4*k +: 3]);
      end else begin
        w_beat_sum = w_beat_sum + piece_val(rd_data[4*k +: 3]);
      end
    end
  end

  // The running total is bounded by 64*VMAX, so this add never wraps.
  assign w_acc_next = r_acc + w_beat_sum;
  assign w_acc_ext  = EXT_W'(w_acc_next);

  // Material scores stay strictly inside the mate magnitude so the search can
  // always tell a forced mate from a large material lead.
  always_comb begin
    w_clamped = w_acc_ext;
    if (w_acc_ext > LIM_HI) begin
      w_clamped = LIM_HI;
    end else if (w_acc_ext < LIM_LO) begin
      w_clamped = LIM_LO;
    end
  end

  assign w_score_mat = w_clamped[SCORE_W-1:0];
  assign w_last_addr = ({1'b0, r_rd_addr} == LAST_ADDR);

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_score   <= '0;
      r_outcome <= 2'b00;
      r_bad     <= 1'b0;
      r_rd_en   <= 1'b0;
      r_rd_addr <= '0;
      r_beat    <= 1'b0;
      r_mate    <= 1'b0;
      r_wtm     <= 1'b0;
      r_acc     <= '0;
    end else begin
      // Read data arrives one cycle after each strobe.
      r_beat <= r_rd_en;
      if (r_beat) begin
        r_acc <= w_acc_next;
        r_bad <= r_bad | w_beat_bad;
      end

      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          r_busy <= 1'b0;
          if (start) begin
            r_busy <= 1'b1;
            r_mate <= mate;
            r_wtm  <= white_to_move;
            if (mate || stalemate) begin
              r_state <= S_TERM;
            end else begin
              r_state   <= S_SCAN;
              r_acc     <= '0;
              r_bad     <= 1'b0;
              r_rd_en   <= 1'b1;
              r_rd_addr <= '0;
            end
          end
        end

        S_SCAN: begin
          if (w_last_addr) begin
            r_rd_en <= 1'b0;
            r_state <= S_DRAIN;
          end else begin
            r_rd_addr <= r_rd_addr + ADDR_STEP;
          end
        end

        // The last group is on rd_data now; w_acc_next already includes it,
        // so the result is registered straight from the combinational total.
        S_DRAIN: begin
          r_state   <= S_DONE;
          r_done    <= 1'b1;
          r_score   <= w_score_mat;
          r_outcome <= 2'b00;
        end

        // Mate dominates stalemate; the loser is the side to move.
        S_TERM: begin
          r_state <= S_DONE;
          r_done  <= 1'b1;
          if (r_mate) begin
            r_score   <= r_wtm ? MATE_NEG : MATE_POS;
            r_outcome <= r_wtm ? 2'b01 : 2'b10;
          end else begin
            r_score   <= '0;
            r_outcome <= 2'b11;
          end
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_rd_en <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign score     = r_score;
  assign outcome   = r_outcome;
  assign bad_piece = r_bad;
  assign rd_en     = r_rd_en;
  assign rd_addr   = r_rd_addr;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_material_eval_seq.sv
// -----------------------------------------------------------------------------
// Bench for material_eval_seq. Two instances: dut_a with default parameters
// (LANES=1, SCORE_W=16, MATE_SCORE=1000) and dut_b with LANES=8, SCORE_W=6,
// MATE_SCORE=31. Drivers issue directed evaluations and push hand-computed
// results; per-instance monitors pop and compare on every done pulse.
// Expected entry layout: {lat[7:0], reads[7:0], bad, outcome[1:0], score[31:0]}
// -----------------------------------------------------------------------------
module tb_material_eval_seq;

  localparam int EXP_W = 51;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // DUT signals
  // ---------------------------------------------------------------------------
  logic        start_a = 1'b0, mate_a = 1'b0, stale_a = 1'b0, wtm_a = 1'b0;
  logic        busy_a, done_a, bad_a, rd_en_a;
  logic [15:0] score_a;
  logic [1:0]  outcome_a;
  logic [5:0]  rd_addr_a;
  logic [3:0]  rd_data_a = '0;
  logic [2:0]  state_a;

  logic        start_b = 1'b0, mate_b = 1'b0, stale_b = 1'b0, wtm_b = 1'b0;
  logic        busy_b, done_b, bad_b, rd_en_b;
  logic [5:0]  score_b;
  logic [1:0]  outcome_b;
  logic [5:0]  rd_addr_b;
  logic [31:0] rd_data_b = '0;
  logic [2:0]  state_b;

  material_eval_seq dut_a (
    .clk(clk), .rst(rst), .start(start_a), .mate(mate_a), .stalemate(stale_a),
    .white_to_move(wtm_a), .busy(busy_a), .done(done_a), .score(score_a),
    .outcome(outcome_a), .bad_piece(bad_a), .rd_en(rd_en_a), .rd_addr(rd_addr_a),
    .rd_data(rd_data_a), .dbg_state(state_a)
  );

  material_eval_seq #(.SCORE_W(6), .LANES(8), .MATE_SCORE(31)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .mate(mate_b), .stalemate(stale_b),
    .white_to_move(wtm_b), .busy(busy_b), .done(done_b), .score(score_b),
    .outcome(outcome_b), .bad_piece(bad_b), .rd_en(rd_en_b), .rd_addr(rd_addr_b),
    .rd_data(rd_data_b), .dbg_state(state_b)
  );

  // ---------------------------------------------------------------------------
  // Board memories (registered read, one cycle latency)
  // ---------------------------------------------------------------------------
  logic [3:0] board_a [64];
  logic [3:0] board_b [64];

  always @(posedge clk) begin
    if (rd_en_a) rd_data_a <= board_a[rd_addr_a];
  end

  always @(posedge clk) begin
    if (rd_en_b) begin
      for (int k = 0; k < 8; k++) rd_data_b[4*k +: 4] <= board_b[rd_addr_b + 6'(k)];
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [EXP_W-1:0] exp_qa[$];
  logic [EXP_W-1:0] exp_qb[$];
  int n_total = 0;
  int n_pass  = 0;
  int t_acc_a = 0;
  int t_acc_b = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic push_exp(input int d, input int sc, input logic [1:0] oc,
                          input logic bd, input int rd, input int lat);
    logic [EXP_W-1:0] e;
    e = {8'(lat), 8'(rd), bd, oc, 32'(sc)};
    if (d == 0) exp_qa.push_back(e);
    else        exp_qb.push_back(e);
  endtask

  task automatic check_done(input string tag, input logic [EXP_W-1:0] e,
                            input longint sc, input logic [1:0] oc, input logic bd,
                            input int rd, input int lat, input logic bz);
    chk({tag, "_score"},   sc,  longint'($signed(e[31:0])));
    chk({tag, "_outcome"}, oc,  e[33:32]);
    chk({tag, "_bad"},     bd,  e[34]);
    chk({tag, "_reads"},   rd,  e[42:35]);
    chk({tag, "_latency"}, lat, e[50:43]);
    chk({tag, "_busy"},    bz,  1);
  endtask

  // Monitor A
  initial begin
    int reads;
    logic [EXP_W-1:0] e;
    reads = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        reads = 0;
      end else begin
        if (rd_en_a) begin
          chk("a_rd_addr", rd_addr_a, reads);
          reads++;
        end
        if (done_a) begin
          if (exp_qa.size() == 0) begin
            n_total++;
            $display("FAIL a_unexpected_done: got done=1 expected no done (t=%0t)", $time);
          end else begin
            e = exp_qa.pop_front();
            check_done("a", e, $signed(score_a), outcome_a, bad_a, reads, cyc - t_acc_a, busy_a);
          end
          reads = 0;
        end
      end
    end
  end

  // Monitor B
  initial begin
    int reads;
    logic [EXP_W-1:0] e;
    reads = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        reads = 0;
      end else begin
        if (rd_en_b) begin
          chk("b_rd_addr", rd_addr_b, reads * 8);
          reads++;
        end
        if (done_b) begin
          if (exp_qb.size() == 0) begin
            n_total++;
            $display("FAIL b_unexpected_done: got done=1 expected no done (t=%0t)", $time);
          end else begin
            e = exp_qb.pop_front();
            check_done("b", e, $signed(score_b), outcome_b, bad_b, reads, cyc - t_acc_b, busy_b);
          end
          reads = 0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic run(input int d, input logic m, input logic s, input logic w);
    @(negedge clk);
    if (d == 0) begin
      mate_a = m; stale_a = s; wtm_a = w; start_a = 1'b1; t_acc_a = cyc;
    end else begin
      mate_b = m; stale_b = s; wtm_b = w; start_b = 1'b1; t_acc_b = cyc;
    end
    @(negedge clk);
    start_a = 1'b0; mate_a = 1'b0; stale_a = 1'b0; wtm_a = 1'b0;
    start_b = 1'b0; mate_b = 1'b0; stale_b = 1'b0; wtm_b = 1'b0;
  endtask

  task automatic wait_idle(input int d);
    int  n;
    bool_loop: begin end
    n = 0;
    while (n < 300) begin
      @(negedge clk);
      n++;
      if (d == 0 && exp_qa.size() == 0 && !busy_a) break;
      if (d == 1 && exp_qb.size() == 0 && !busy_b) break;
    end
    if ((d == 0 && (exp_qa.size() != 0 || busy_a)) ||
        (d == 1 && (exp_qb.size() != 0 || busy_b))) begin
      n_total++;
      $display("FAIL timeout_%0d: got no done within 300 cycles expected done", d);
    end
  endtask

  task automatic clear_a();
    for (int i = 0; i < 64; i++) board_a[i] = 4'd0;
  endtask

  task automatic clear_b();
    for (int i = 0; i < 64; i++) board_b[i] = 4'd0;
  endtask

  task automatic load_start_a();
    logic [3:0] back [8];
    back = '{4'd4, 4'd2, 4'd3, 4'd5, 4'd6, 4'd3, 4'd2, 4'd4};
    clear_a();
    for (int i = 0; i < 8; i++) begin
      board_a[i]      = back[i];
      board_a[8 + i]  = 4'd1;
      board_a[48 + i] = 4'd9;
      board_a[56 + i] = back[i] | 4'b1000;
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_busy"},    busy_a,    0);
    chk({tag, "_done"},    done_a,    0);
    chk({tag, "_rd_en"},   rd_en_a,   0);
    chk({tag, "_rd_addr"}, rd_addr_a, 0);
    chk({tag, "_score"},   score_a,   0);
    chk({tag, "_outcome"}, outcome_a, 0);
    chk({tag, "_bad"},     bad_a,     0);
    chk({tag, "_state"},   state_a,   0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int n;
    load_start_a();
    clear_b();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_reset_state("a_por");
    chk("b_por_busy",  busy_b,  0);
    chk("b_por_score", score_b, 0);
    chk("b_por_rd_en", rd_en_b, 0);

    // ---- dut_a, LANES=1 ----
    push_exp(0, 0, 2'b00, 1'b0, 64, 66);          // start position
    run(0, 0, 0, 0); wait_idle(0);

    board_a[3] = 4'd0;                             // white queen removed
    push_exp(0, -10, 2'b00, 1'b0, 64, 66);
    run(0, 0, 0, 0); wait_idle(0);

    push_exp(0, -1000, 2'b01, 1'b0, 0, 2);         // white mated
    run(0, 1, 0, 1); wait_idle(0);

    push_exp(0, 0, 2'b11, 1'b0, 0, 2);             // stalemate, imbalanced board
    run(0, 0, 1, 1); wait_idle(0);

    push_exp(0, 1000, 2'b10, 1'b0, 0, 2);          // mate and stalemate, black mated
    run(0, 1, 1, 0); wait_idle(0);

    // Reset in the middle of a scan; square 5 invalid so bad_piece is set first.
    load_start_a();
    board_a[5] = 4'b0111;
    run(0, 0, 0, 0);
    repeat (19) @(negedge clk);
    chk("a_abort_busy_before", busy_a, 1);
    chk("a_abort_bad_before",  bad_a,  1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_reset_state("a_abort");
    repeat (80) @(negedge clk);                    // monitor flags any stray done
    chk("a_abort_idle_busy", busy_a, 0);

    // start re-issued while busy (with mate set) must be ignored.
    load_start_a();
    board_a[56] = 4'd0;                            // black rook removed
    push_exp(0, 5, 2'b00, 1'b0, 64, 66);
    run(0, 0, 0, 0);
    repeat (5) @(negedge clk);
    start_a = 1'b1; mate_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; mate_a = 1'b0;
    wait_idle(0);

    // start during the DONE cycle must be ignored.
    load_start_a();
    push_exp(0, 0, 2'b00, 1'b0, 64, 66);
    run(0, 0, 0, 0);
    n = 0;
    while (!done_a && n < 200) begin @(negedge clk); n++; end
    chk("a_done_seen", done_a, 1);
    start_a = 1'b1; mate_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; mate_a = 1'b0;
    chk("a_start_in_done_busy",  busy_a,  0);
    chk("a_start_in_done_state", state_a, 0);
    @(negedge clk);
    chk("a_start_in_done_rd_en", rd_en_a, 0);

    // ---- dut_b, LANES=8, SCORE_W=6, MATE_SCORE=31 ----
    clear_b();
    board_b[3] = 4'd5; board_b[4] = 4'd6; board_b[60] = 4'd14;   // K+Q vs K
    push_exp(1, 10, 2'b00, 1'b0, 8, 10);
    run(1, 0, 0, 0); wait_idle(1);

    clear_b();
    board_b[4] = 4'd6; board_b[60] = 4'd14;
    for (int i = 16; i < 25; i++) board_b[i] = 4'd5;            // nine white queens
    push_exp(1, 30, 2'b00, 1'b0, 8, 10);
    run(1, 0, 0, 0); wait_idle(1);

    board_b[12] = 4'b0111;                                       // invalid piece
    push_exp(1, 30, 2'b00, 1'b1, 8, 10);
    run(1, 0, 0, 0); wait_idle(1);

    clear_b();
    board_b[4] = 4'd6; board_b[60] = 4'd14;
    for (int i = 16; i < 19; i++) board_b[i] = 4'd5;
    board_b[19] = 4'd1;                                          // +31, one over limit
    push_exp(1, 30, 2'b00, 1'b0, 8, 10);
    run(1, 0, 0, 0); wait_idle(1);

    clear_b();
    board_b[4] = 4'd6; board_b[60] = 4'd14;
    for (int i = 40; i < 45; i++) board_b[i] = 4'd13;           // five black queens
    push_exp(1, -30, 2'b00, 1'b0, 8, 10);
    run(1, 0, 0, 0); wait_idle(1);

    push_exp(1, -31, 2'b01, 1'b0, 0, 2);
    run(1, 1, 0, 1); wait_idle(1);

    push_exp(1, 31, 2'b10, 1'b0, 0, 2);
    run(1, 1, 0, 0); wait_idle(1);

    push_exp(1, 0, 2'b11, 1'b0, 0, 2);
    run(1, 0, 1, 0); wait_idle(1);

    repeat (5) @(negedge clk);
    if (exp_qa.size() != 0 || exp_qb.size() != 0) begin
      n_total++;
      $display("FAIL leftover_expect: got %0d/%0d pending expected 0",
               exp_qa.size(), exp_qb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Hard stop in case a driver loop stalls.
  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish expected finish");
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/material_eval_seq.md
Name: material_eval_seq

Overview:
- Sequential, parametrised position evaluator for the chess engine datapath.
- On `start`, it scans the 64-square board memory over a registered read port, LANES squares per cycle, and accumulates the signed material balance (positive = white ahead).
- Terminal positions (checkmate, stalemate) skip the scan and return a fixed score plus an outcome code.
- Results feed the search controller through a start/done handshake.

Parameters:
- SCORE_W, 16, width of signed score output; range 6..32.
- LANES, 1, squares read per cycle; one of 1, 2, 4, 8, 16, 32, 64.
- VAL_P, 1, pawn value.
- VAL_N, 3, knight value.
- VAL_B, 3, bishop value.
- VAL_R, 5, rook value.
- VAL_Q, 10, queen value.
- MATE_SCORE, 1000, magnitude reported for checkmate; must satisfy 2 <= MATE_SCORE <= 2^(SCORE_W-1)-1.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request evaluation; honoured only in IDLE.
- mate  in  1  side to move is checkmated.
- stalemate  in  1  side to move has no legal move and is not in check.
- white_to_move  in  1  1 = white to move.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse; score and outcome are valid from this cycle.
- score  out  SCORE_W  signed evaluation, held until the next done.
- outcome  out  2  00 ongoing, 10 white wins, 01 black wins, 11 draw.
- bad_piece  out  1  sticky per evaluation; set if any square holds type 7.
- rd_en  out  1  board read strobe.
- rd_addr  out  6  first square of the group; always a multiple of LANES.
- rd_data  in  4*LANES  lane k = square rd_addr+k, returned 1 cycle after rd_en.

Behaviour:
- Piece code encoding:
  - bit3 is colour: 0 white, 1 black.
  - bits[2:0] are type: 0 empty, 1 P, 2 N, 3 B, 4 R, 5 Q, 6 K (value 0), 7 invalid (value 0, sets bad_piece).
- Reset values: busy=0, done=0, rd_en=0, rd_addr=0, score=0, outcome=00, bad_piece=0; FSM returns to IDLE.
- Reset mid-scan aborts the scan with no done pulse.
- FSM states: IDLE, SCAN, DRAIN, TERM, DONE.
- mate, stalemate and white_to_move are captured in the cycle start is accepted.
- start while not IDLE is ignored; start in the DONE cycle is also ignored.
- IDLE transitions on accepted start:
  - mate or stalemate -> TERM.
  - otherwise -> SCAN; accumulator cleared, bad_piece cleared.
- SCAN:
  - rd_en=1; rd_addr steps 0, LANES, 2*LANES, ... over N = 64/LANES consecutive cycles.
  - After the last address, go to DRAIN for the final data cycle, then DONE.
- Accumulate, on each data beat:
  - Sum the lane values: white adds, black subtracts.
  - Accumulate in an internal signed register wide enough to be exact for 64 queens.
- DONE (material path):
  - score = accumulator clamped to [-(MATE_SCORE-1), +(MATE_SCORE-1)].
  - outcome = 00; done=1 for one cycle; then IDLE.
- Latency, material path: done asserts exactly N+2 cycles after the start-accept edge (66 for LANES=1, 10 for LANES=8).
- TERM: no reads issued; done asserts 2 cycles after the start-accept edge.
  - mate with white_to_move=1: score = -MATE_SCORE, outcome = 01.
  - mate with white_to_move=0: score = +MATE_SCORE, outcome = 10.
  - stalemate only: score = 0, outcome = 11.
  - mate and stalemate both set: mate wins.
- busy is low in IDLE and high in SCAN, DRAIN, TERM and DONE.

Test Plan:
- Standard start position, LANES=1, start -> 64 rd_en cycles with addresses 0..63; done at cycle 66; score=0, outcome=00, bad_piece=0.
- Board with white K, white Q, black K only, LANES=8 -> rd_addr 0,8,...,56; done at cycle 10; score=+10.
- mate=1, white_to_move=1 -> rd_en never asserted; done at cycle 2; score=-1000, outcome=01. Repeat with white_to_move=0 -> score=+1000, outcome=10.
- stalemate=1 with a material-imbalanced board -> score=0, outcome=11, no reads.
- SCORE_W=6, MATE_SCORE=31, board with 9 white queens and 2 kings -> score=+30 (clamped); square 12 set to 4'b0111 -> bad_piece=1, score unchanged.
- rst pulsed at cycle 20 of a LANES=1 scan -> no done pulse; all outputs at reset values. start re-issued while busy is ignored; a fresh start completes normally.
